// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, N_BIT data (LSB first), optional parity, 1 or 2 stop bits.
// Optional line-break generation is built only when UART_TX_BREAK_EN is defined.
module uart_tx_cfg #(
  parameter int N_BIT = 8,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [N_BIT-1:0] din,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
`ifdef UART_TX_BREAK_EN
  input  logic             tx_break,
`endif
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int BW = $clog2(N_BIT + 3);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(N_BIT - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [BW-1:0] BRK_LAST  = BW'(N_BIT + 1);
  localparam logic [BW-1:0] BRK_FULL  = BW'(N_BIT + 2);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    BREAK,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [N_BIT-1:0] data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    bit_end   = s_tick && (tick_q == TICK_LAST);

    if (s_tick) tick_d = bit_end ? '0 : tick_q + 1'b1;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = BREAK;
          stop2_d = 1'b0;
        end else if (tx_start) begin
`else
        if (tx_start) begin
`endif
          state_d   = START;
          data_d    = din;
          par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d = (parity_mode == 2'b10) ? ~^din : ^din;
          stop2_d   = stop2;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      // Data is shifted out so the line bit is always data_q[0].
      DATA: begin
        if (bit_end) begin
          data_d = data_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BW'(1);
          end else begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // bit_q counts elapsed bit periods and saturates once the minimum break has passed.
      BREAK: begin
        if (bit_q == BRK_FULL) begin
          if (!tx_break) begin
            state_d = STOP;
            tick_d  = '0;
            bit_d   = '0;
          end
        end else if (bit_end) begin
          if ((bit_q == BRK_LAST) && !tx_break) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[0];
      PARITY:  tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = 1'b0;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg (N_BIT=8, OVS=16) with immediate-assertion checks.
// Break sequence is exercised only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif

  int checks    = 0;
  int errors    = 0;
  int doneCount = 0;
  int doneBase  = 0;

  uart_tx_cfg #(.N_BIT(8), .OVS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .parity_mode  (parity_mode),
    .stop2        (stop2),
`ifdef UART_TX_BREAK_EN
    .tx_break     (tx_break),
`endif
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // Counts every done pulse so the number per frame can be checked.
  always @(negedge clk) if (tx_done_tick) doneCount++;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One oversampling tick, returning on the falling edge after it has been consumed.
  task automatic applyTick();
    @(negedge clk) s_tick = 1'b1;
    @(negedge clk) s_tick = 1'b0;
  endtask

  // Single-cycle start request, then the line must already show the start bit.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    @(negedge clk);
    din         = d;
    parity_mode = pm;
    stop2       = s2;
    tx_start    = 1'b1;
    @(negedge clk) tx_start = 1'b0;
    checkOutput("accept_tx", 16'(tx), 16'h0);
    checkOutput("accept_busy", 16'(tx_busy), 16'h1);
  endtask

  // Walks a frame bit by bit (16 ticks each), frame given LSB first, ending in the done cycle.
  task automatic runFrame(input logic [11:0] frame, input int nbits, input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int t = 0; t < 16; t++) begin
        checkOutput({tag, "_tx"}, 16'(tx), 16'(frame[b]));
        if (t == 0) checkOutput({tag, "_busy"}, 16'(tx_busy), 16'h1);
        applyTick();
      end
    end
    checkOutput({tag, "_done"}, 16'(tx_done_tick), 16'h1);
    checkOutput({tag, "_end_busy"}, 16'(tx_busy), 16'h0);
    checkOutput({tag, "_end_tx"}, 16'(tx), 16'h1);
  endtask

  // Linear directed sequence covering reset, parity modes, stop bits, back-to-back and abort.
  initial begin
    rst_n       = 1'b0;
    s_tick      = 1'b0;
    tx_start    = 1'b0;
    din         = 8'h00;
    parity_mode = 2'b00;
    stop2       = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 16'(tx), 16'h1);
    checkOutput("reset_busy", 16'(tx_busy), 16'h0);
    checkOutput("reset_done", 16'(tx_done_tick), 16'h0);
    rst_n = 1'b1;
    applyTick();
    checkOutput("idle_tx", 16'(tx), 16'h1);
    checkOutput("idle_busy", 16'(tx_busy), 16'h0);

    doneBase = doneCount;
    applyStimulus(8'hA5, 2'b01, 1'b0);
    runFrame({1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, "a5_even");
    @(negedge clk) checkOutput("a5_done_low", 16'(tx_done_tick), 16'h0);
    #1 checkOutput("a5_done_count", 16'(doneCount - doneBase), 16'h1);

    applyStimulus(8'h07, 2'b10, 1'b0);
    runFrame({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "07_odd");
    @(negedge clk) checkOutput("07_odd_done_low", 16'(tx_done_tick), 16'h0);

    applyStimulus(8'h07, 2'b00, 1'b0);
    runFrame({2'b00, 1'b1, 8'h07, 1'b0}, 10, "07_none");
    @(negedge clk) checkOutput("07_none_done_low", 16'(tx_done_tick), 16'h0);

    applyStimulus(8'h3C, 2'b11, 1'b0);
    runFrame({2'b00, 1'b1, 8'h3C, 1'b0}, 10, "3c_rsvd");
    @(negedge clk) checkOutput("3c_done_low", 16'(tx_done_tick), 16'h0);

    // Two stop bits; inputs change right after acceptance and must not leak into the frame.
    applyStimulus(8'h00, 2'b00, 1'b1);
    din         = 8'hFF;
    parity_mode = 2'b01;
    stop2       = 1'b0;
    runFrame({1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, "stop2");
    @(negedge clk) checkOutput("stop2_done_low", 16'(tx_done_tick), 16'h0);

    // tx_start held high: second frame is accepted in the done cycle of the first.
    doneBase = doneCount;
    @(negedge clk);
    din         = 8'h10;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    tx_start    = 1'b1;
    @(negedge clk);
    checkOutput("b2b_accept_tx", 16'(tx), 16'h0);
    checkOutput("b2b_accept_busy", 16'(tx_busy), 16'h1);
    din = 8'h11;
    runFrame({2'b00, 1'b1, 8'h10, 1'b0}, 10, "b2b_first");
    @(negedge clk);
    checkOutput("b2b_next_tx", 16'(tx), 16'h0);
    checkOutput("b2b_next_busy", 16'(tx_busy), 16'h1);
    checkOutput("b2b_next_done", 16'(tx_done_tick), 16'h0);
    din      = 8'h12;
    tx_start = 1'b0;
    runFrame({2'b00, 1'b1, 8'h11, 1'b0}, 10, "b2b_second");
    @(negedge clk);
    checkOutput("b2b_idle_tx", 16'(tx), 16'h1);
    checkOutput("b2b_idle_busy", 16'(tx_busy), 16'h0);
    #1 checkOutput("b2b_done_count", 16'(doneCount - doneBase), 16'h2);

    // Reset 50 ticks into a frame aborts it without a done pulse.
    applyStimulus(8'h5A, 2'b10, 1'b0);
    repeat (50) applyTick();
    doneBase = doneCount;
    @(negedge clk) rst_n = 1'b0;
    #1;
    checkOutput("abort_tx", 16'(tx), 16'h1);
    checkOutput("abort_busy", 16'(tx_busy), 16'h0);
    checkOutput("abort_done", 16'(tx_done_tick), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    applyTick();
    checkOutput("abort_idle_tx", 16'(tx), 16'h1);
    #1 checkOutput("abort_done_count", 16'(doneCount - doneBase), 16'h0);
    applyStimulus(8'h5A, 2'b10, 1'b0);
    runFrame({1'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11, "after_abort");
    @(negedge clk) checkOutput("after_abort_done_low", 16'(tx_done_tick), 16'h0);

`ifdef UART_TX_BREAK_EN
    // Break pulsed for 10 ticks: 160 ticks low, one stop bit, done; tx_start ignored throughout.
    @(negedge clk);
    tx_break = 1'b1;
    tx_start = 1'b1;
    stop2    = 1'b1;
    @(negedge clk);
    checkOutput("brk_accept_tx", 16'(tx), 16'h0);
    checkOutput("brk_accept_busy", 16'(tx_busy), 16'h1);
    for (int i = 0; i < 160; i++) begin
      if (i == 10) tx_break = 1'b0;
      checkOutput("brk_low_tx", 16'(tx), 16'h0);
      if (i % 16 == 0) checkOutput("brk_low_busy", 16'(tx_busy), 16'h1);
      applyTick();
    end
    for (int i = 0; i < 16; i++) begin
      checkOutput("brk_stop_tx", 16'(tx), 16'h1);
      checkOutput("brk_stop_busy", 16'(tx_busy), 16'h1);
      applyTick();
    end
    checkOutput("brk_done", 16'(tx_done_tick), 16'h1);
    tx_start = 1'b0;
    stop2    = 1'b0;
    @(negedge clk);
    checkOutput("brk_idle_tx", 16'(tx), 16'h1);
    checkOutput("brk_idle_busy", 16'(tx_busy), 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, next generation of the fixed 8-bit/even-parity serial TX. It serialises a parallel word into an asynchronous frame with configurable data width, oversampling ratio, per-frame parity mode and one or two stop bits. It sits between the baud-tick generator (which supplies `s_tick`) and the pad, alongside the UART RX. It reports frame acceptance through `tx_busy` and frame completion through `tx_done_tick`.

## Interface
- `N_BIT`, default 8: data bits per frame; legal range 5..9.
- `OVS`, default 16: `s_tick` pulses per bit; legal range ≥2. Tick counter is `$clog2(OVS)` bits wide.
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst_n`  input  1: asynchronous active-low reset.
- `s_tick`  input  1: oversampling tick, one `clk` wide.
- `tx_start`  input  1: request to send `din`; sampled only in IDLE.
- `din`  input  N_BIT: data word, LSB sent first.
- `parity_mode`  input  2: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `stop2`  input  1: 1 selects two stop bits, 0 selects one.
- `tx`  output  1: serial line, registered, idles high.
- `tx_busy`  output  1: frame in progress.
- `tx_done_tick`  output  1: one-cycle pulse at frame end.
- `tx_break`  input  1: present only with `UART_TX_BREAK_EN`.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP; BREAK is added with the macro.
- **IDLE:**
  - `tx`=1, counters cleared.
  - `tx_start`=1 accepts the request in that cycle.
  - `din`, `parity_mode` and `stop2` are latched into shadow registers on acceptance, so input changes after acceptance do not affect the frame.
- **START:**
  - `tx`=0.
  - Leaves on the `s_tick` where tick_count==OVS-1, then goes to DATA with bit_count=0.
- **DATA:**
  - `tx`=data[bit_count].
  - At each bit end (`s_tick` && tick_count==OVS-1), bit_count increments.
  - After bit N_BIT-1 ends: go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY:**
  - `tx` = ^data for even, ~^data for odd.
  - Lasts one bit, then goes to STOP.
- **STOP:**
  - `tx`=1 for OVS ticks, or 2·OVS ticks when `stop2`=1.
  - Then goes to IDLE.
- tick_count increments only on `s_tick` and wraps to 0 at OVS-1. `s_tick` has no other effect.
- `tx_start` outside IDLE is ignored; there is no queueing.
- Reset values (async on `rst_n`=0): state IDLE, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, counters 0, shadow registers 0.
- Reset asserted mid-frame aborts the frame immediately: `tx` returns high and no done pulse is issued.

## Timing
- The cycle after `tx_start` is accepted: `tx`=0 and `tx_busy`=1.
- Frame length is (1 + N_BIT + P + S)·OVS `s_tick` pulses, where P is 0 or 1 and S is 1 or 2. The start bit is measured from the first `s_tick` after acceptance.
- `tx_done_tick` is high for exactly one cycle: the first IDLE cycle after STOP. `tx_busy` is 0 in that same cycle.
- A `tx_start` in the `tx_done_tick` cycle is accepted. This gives back-to-back frames with no extra idle bit.
- Every `tx` transition occurs on the `clk` edge following the qualifying `s_tick`.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- **Defined:**
  - The `tx_break` port and the BREAK state exist.
  - In IDLE, `tx_break`=1 takes priority over `tx_start`.
  - In BREAK, `tx`=0 and `tx_busy`=1.
  - BREAK exits only once `tx_break`=0 and at least (N_BIT+2)·OVS ticks have elapsed. It then goes to STOP for one stop bit (`stop2` is ignored), followed by `tx_done_tick`.
  - `tx_break` asserted mid-frame is ignored until IDLE.
- **Undefined:** no `tx_break` port, no BREAK state, and no break logic is synthesised.

## Test plan
- N_BIT=8, OVS=16, `parity_mode`=01, `stop2`=0, `din`=8'hA5 → line shows 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 16 ticks, total 176 ticks. One `tx_done_tick` pulse.
- `din`=8'h07, `parity_mode`=10 → parity bit 0. `parity_mode`=00 and 11 → no parity bit, frame lasts 160 ticks.
- `stop2`=1, `din`=8'h00, no parity → stop high for 32 ticks, total 176 ticks. Changing `din`, `parity_mode` or `stop2` mid-frame has no effect on the frame.
- `tx_start` held high continuously, `din` incrementing → back-to-back frames with no idle gap. Each frame carries the `din` value present in its acceptance cycle. `tx_start` pulses during a frame are ignored.
- Drive `rst_n` low at tick 50 of a frame → `tx`=1, `tx_busy`=0 and `tx_done_tick`=0 immediately. A new `tx_start` after release sends a clean frame.
- With `UART_TX_BREAK_EN` defined, pulse `tx_break` for 10 ticks (N_BIT=8, OVS=16) → `tx` low for 160 ticks, then high for 16 ticks, then `tx_done_tick`. `tx_start` is ignored throughout.
